// File: rtl/wb_regfile_if.sv
// Bus bundle for the write-back register file: write-back controls, read addresses
// and the read/forwarding/counter results.
interface wb_regfile_if #(
    parameter int CNT_W = 32
);
    logic             RegWE;
    logic [4:0]       WriteRegAddr;
    logic [1:0]       WriteDataSrc;
    logic [31:0]      dataMem;
    logic [31:0]      ALURes;
    logic [31:0]      PCplus8;
    logic [4:0]       ReadAddr1;
    logic [4:0]       ReadAddr2;
    logic [31:0]      ReadData1;
    logic [31:0]      ReadData2;
    logic [31:0]      WriteBackData;
    logic [CNT_W-1:0] WriteCount;

    modport master (
        output RegWE, WriteRegAddr, WriteDataSrc, dataMem, ALURes, PCplus8,
        output ReadAddr1, ReadAddr2,
        input  ReadData1, ReadData2, WriteBackData, WriteCount
    );

    modport slave (
        input  RegWE, WriteRegAddr, WriteDataSrc, dataMem, ALURes, PCplus8,
        input  ReadAddr1, ReadAddr2,
        output ReadData1, ReadData2, WriteBackData, WriteCount
    );
endinterface

// File: rtl/wb_regfile.sv
// 32x32 write-back register file with asynchronous read ports and a committed-write counter.
// Define WB_BYPASS_EN to return the committing write-back value on a matching read in the same cycle.
module wb_regfile #(
    parameter int CNT_W = 32
) (
    input logic          clk,
    input logic          rst,
    wb_regfile_if.slave  bus
);
    logic [31:0]      regs [32];
    logic [31:0]      wb_data;
    logic [31:0]      rd1;
    logic [31:0]      rd2;
    logic             commit;
    logic [CNT_W-1:0] write_count;

    // Source 11 yields zero and also blocks the write through the commit term.
    always_comb begin
        wb_data = '0;
        case (bus.WriteDataSrc)
            2'b00:   wb_data = bus.ALURes;
            2'b01:   wb_data = bus.dataMem;
            2'b10:   wb_data = bus.PCplus8;
            default: wb_data = '0;
        endcase
    end

    assign commit = bus.RegWE && (bus.WriteRegAddr != 5'd0) &&
                    (bus.WriteDataSrc != 2'b11) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
            write_count <= '0;
        end else if (commit) begin
            regs[bus.WriteRegAddr] <= wb_data;
            write_count            <= write_count + CNT_W'(1);
        end
    end

    // Index 0 is forced to zero here; commit already excludes address 0 from the bypass.
    always_comb begin
        rd1 = (bus.ReadAddr1 == 5'd0) ? 32'h0 : regs[bus.ReadAddr1];
        rd2 = (bus.ReadAddr2 == 5'd0) ? 32'h0 : regs[bus.ReadAddr2];
`ifdef WB_BYPASS_EN
        if (commit && (bus.ReadAddr1 == bus.WriteRegAddr)) rd1 = wb_data;
        if (commit && (bus.ReadAddr2 == bus.WriteRegAddr)) rd2 = wb_data;
`endif
    end

    assign bus.ReadData1     = rd1;
    assign bus.ReadData2     = rd2;
    assign bus.WriteBackData = wb_data;
    assign bus.WriteCount    = write_count;
endmodule
